// File: rtl/frame_link_arbiter.sv
// Two-requester round-robin arbiter that serializes the winning request into a
// framed byte stream: C9, type, addr, data1, [data2], 9C, with a forced idle gap.
module frame_link_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        len0,
    input  logic        len1,
    input  logic [7:0]  addr0,
    input  logic [7:0]  addr1,
    input  logic [15:0] dat0,
    input  logic [15:0] dat1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [7:0]  word_out,
    output logic        word_valid,
    output logic        busy
);

    localparam logic [7:0] BEGIN_WORD = 8'hC9;
    localparam logic [7:0] END_WORD   = 8'h9C;
    localparam logic [7:0] TYPE_SHORT = 8'h60;
    localparam logic [7:0] TYPE_LONG  = 8'h61;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BEGIN,
        S_TYPE,
        S_ADDR,
        S_DATA1,
        S_DATA2,
        S_END
    } state_t;

    state_t      r_state;
    logic        r_last1;   // 1 when requester 1 was served most recently
    logic        r_len;
    logic [7:0]  r_addr;
    logic [15:0] r_dat;

    // Requester 1 wins when it is alone, or in contention when requester 0 was served last.
    logic w_any_req;
    logic w_pick1;
    assign w_any_req = req0 | req1;
    assign w_pick1   = req1 & (~req0 | ~r_last1);

    // NOTE: every output is a register updated alongside the state, so each
    // state's word appears in the cycle the FSM sits in that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_last1    <= 1'b1;
            r_len      <= 1'b0;
            r_addr     <= 8'h00;
            r_dat      <= 16'h0000;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            word_out   <= 8'h00;
            word_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state    <= S_BEGIN;
                        r_last1    <= w_pick1;
                        r_len      <= w_pick1 ? len1  : len0;
                        r_addr     <= w_pick1 ? addr1 : addr0;
                        r_dat      <= w_pick1 ? dat1  : dat0;
                        gnt0       <= ~w_pick1;
                        gnt1       <= w_pick1;
                        word_out   <= BEGIN_WORD;
                        word_valid <= 1'b1;
                        busy       <= 1'b1;
                    end else begin
                        word_out   <= 8'h00;
                        word_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                S_BEGIN: begin
                    r_state  <= S_TYPE;
                    word_out <= r_len ? TYPE_LONG : TYPE_SHORT;
                end
                S_TYPE: begin
                    r_state  <= S_ADDR;
                    word_out <= r_addr;
                end
                S_ADDR: begin
                    r_state  <= S_DATA1;
                    word_out <= r_dat[7:0];
                end
                S_DATA1: begin
                    if (r_len) begin
                        r_state  <= S_DATA2;
                        word_out <= r_dat[15:8];
                    end else begin
                        r_state  <= S_END;
                        word_out <= END_WORD;
                    end
                end
                S_DATA2: begin
                    r_state  <= S_END;
                    word_out <= END_WORD;
                end
                S_END: begin
                    // Always pass through IDLE so frames are separated by a non-valid cycle.
                    r_state    <= S_IDLE;
                    word_out   <= 8'h00;
                    word_valid <= 1'b0;
                    busy       <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    word_out   <= 8'h00;
                    word_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_link_arbiter.sv
// Bench for frame_link_arbiter: directed frame scenarios plus random traffic,
// checked every cycle against a queue-based transaction model of the link.
module tb_frame_link_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        len0 = 1'b0, len1 = 1'b0;
    logic [7:0]  addr0 = 8'h00, addr1 = 8'h00;
    logic [15:0] dat0 = 16'h0000, dat1 = 16'h0000;
    logic        gnt0, gnt1, word_valid, busy;
    logic [7:0]  word_out;

    frame_link_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .len0(len0), .len1(len1),
        .addr0(addr0), .addr1(addr1), .dat0(dat0), .dat1(dat1),
        .gnt0(gnt0), .gnt1(gnt1), .word_out(word_out),
        .word_valid(word_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Transaction model: a granted frame becomes a queue of bytes drained one per
    // cycle; once drained the link shows one idle cycle before sampling again.
    logic [7:0] m_q[$];
    logic       m_valid = 1'b0, m_busy = 1'b0, m_g0 = 1'b0, m_g1 = 1'b0;
    logic [7:0] m_word = 8'h00;
    int         m_last = 1;

    task automatic model_edge();
        int          w;
        logic        l;
        logic [7:0]  a;
        logic [15:0] d;
        m_g0 = 1'b0;
        m_g1 = 1'b0;
        if (reset) begin
            m_q.delete();
            m_valid = 1'b0; m_word = 8'h00; m_busy = 1'b0; m_last = 1;
        end else if (m_q.size() > 0) begin
            m_word = m_q.pop_front(); m_valid = 1'b1; m_busy = 1'b1;
        end else if (m_valid) begin
            m_valid = 1'b0; m_word = 8'h00; m_busy = 1'b0;
        end else if (req0 || req1) begin
            w = (req0 && req1) ? 1 - m_last : (req1 ? 1 : 0);
            m_last = w;
            l = (w == 1) ? len1  : len0;
            a = (w == 1) ? addr1 : addr0;
            d = (w == 1) ? dat1  : dat0;
            m_q.push_back(l ? 8'h61 : 8'h60);
            m_q.push_back(a);
            m_q.push_back(d[7:0]);
            if (l) m_q.push_back(d[15:8]);
            m_q.push_back(8'h9C);
            m_word = 8'hC9; m_valid = 1'b1; m_busy = 1'b1;
            m_g0 = (w == 0); m_g1 = (w == 1);
        end else begin
            m_valid = 1'b0; m_word = 8'h00; m_busy = 1'b0;
        end
    endtask

    logic [7:0] stream[$];
    logic [7:0] exp_s[$];
    int         glog[$];
    int         cyc = 0;
    int         g1_at = -1;
    logic       hold = 1'b0;

    task automatic clear_log();
        stream.delete();
        glog.delete();
        cyc = 0;
        g1_at = -1;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        check("word_valid", {15'd0, word_valid}, {15'd0, m_valid});
        check("word_out",   {8'd0, word_out},    {8'd0, m_word});
        check("busy",       {15'd0, busy},       {15'd0, m_busy});
        check("gnt0",       {15'd0, gnt0},       {15'd0, m_g0});
        check("gnt1",       {15'd0, gnt1},       {15'd0, m_g1});
        if (word_valid === 1'b1) stream.push_back(word_out);
        if (gnt0 === 1'b1) glog.push_back(0);
        if (gnt1 === 1'b1) begin
            glog.push_back(1);
            if (g1_at < 0) g1_at = cyc;
        end
        if (!hold) begin
            if (m_g0) req0 = 1'b0;
            if (m_g1) req1 = 1'b1 ? 1'b0 : 1'b0;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_len"}, 16'(stream.size()), 16'(exp_s.size()));
        for (int i = 0; i < exp_s.size() && i < stream.size(); i++)
            check($sformatf("%s_w%0d", tag, i), {8'd0, stream[i]}, {8'd0, exp_s[i]});
    endtask

    initial begin
        // Reset state
        steps(2);
        check("rst_valid", {15'd0, word_valid}, 16'd0);
        check("rst_word",  {8'd0, word_out},    16'd0);
        reset = 1'b0;

        // Single short frame from requester 0
        clear_log();
        req0 = 1'b1; len0 = 1'b0; addr0 = 8'h12; dat0 = 16'h0034;
        steps(7);
        exp_s = '{8'hC9, 8'h60, 8'h12, 8'h34, 8'h9C};
        check_stream("f0");
        check("f0_ngnt", 16'(glog.size()), 16'd1);
        if (glog.size() > 0) check("f0_gnt", 16'(glog[0]), 16'd0);

        // Single long frame from requester 1
        clear_log();
        req1 = 1'b1; len1 = 1'b1; addr1 = 8'h05; dat1 = 16'hBBAA;
        steps(8);
        exp_s = '{8'hC9, 8'h61, 8'h05, 8'hAA, 8'hBB, 8'h9C};
        check_stream("f1");
        check("f1_ngnt", 16'(glog.size()), 16'd1);
        if (glog.size() > 0) check("f1_gnt", 16'(glog[0]), 16'd1);

        // Continuous contention right after reset: strict alternation from requester 0
        reset = 1'b1; steps(1); reset = 1'b0;
        clear_log();
        hold = 1'b1;
        req0 = 1'b1; len0 = 1'b0; addr0 = 8'h10; dat0 = 16'h0001;
        req1 = 1'b1; len1 = 1'b0; addr1 = 8'h20; dat1 = 16'h0002;
        steps(23);
        hold = 1'b0; req0 = 1'b0; req1 = 1'b0;
        steps(3);
        check("rr_ngnt", 16'(glog.size()), 16'd4);
        for (int i = 0; i < 4 && i < glog.size(); i++)
            check($sformatf("rr_gnt%0d", i), 16'(glog[i]), 16'(i % 2));
        check("rr_words", 16'(stream.size()), 16'd20);

        // Reset aborts a frame after ADDR; a request held through reset waits for IDLE
        clear_log();
        req0 = 1'b1; len0 = 1'b1; addr0 = 8'h33; dat0 = 16'h5544;
        steps(4);
        reset = 1'b1;
        req1 = 1'b1; len1 = 1'b0; addr1 = 8'h66; dat1 = 16'h0088;
        steps(1);
        check("abort_valid", {15'd0, word_valid}, 16'd0);
        check("abort_busy",  {15'd0, busy},       16'd0);
        exp_s = '{8'hC9, 8'h61, 8'h33, 8'h44};
        check_stream("abort");
        check("abort_ngnt", 16'(glog.size()), 16'd1);
        reset = 1'b0;
        clear_log();
        steps(7);
        exp_s = '{8'hC9, 8'h60, 8'h66, 8'h88, 8'h9C};
        check_stream("after_abort");

        // Marker values in address and payload pass through unchanged
        clear_log();
        req0 = 1'b1; len0 = 1'b1; addr0 = 8'h9C; dat0 = 16'h61C9;
        steps(8);
        exp_s = '{8'hC9, 8'h61, 8'h9C, 8'hC9, 8'h61, 8'h9C};
        check_stream("verbatim");

        // Late request during DATA1; captured fields immune to later input changes
        clear_log();
        req0 = 1'b1; len0 = 1'b1; addr0 = 8'h40; dat0 = 16'h2211;
        steps(4);
        req1 = 1'b1; len1 = 1'b0; addr1 = 8'h55; dat1 = 16'h0077;
        addr0 = 8'hEE; dat0 = 16'h0000; len0 = 1'b0;
        steps(1);
        addr1 = 8'h56;
        steps(10);
        exp_s = '{8'hC9, 8'h61, 8'h40, 8'h11, 8'h22, 8'h9C, 8'hC9, 8'h60, 8'h56, 8'h77, 8'h9C};
        check_stream("late");
        check("late_g1_cycle", 16'(g1_at), 16'd8);

        // Random traffic, including withdrawn requests and occasional resets
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if (!req0 && $urandom_range(0, 3) == 0) begin
                req0 = 1'b1; len0 = 1'($urandom_range(0, 1));
                addr0 = 8'($urandom); dat0 = 16'($urandom);
            end else if (req0 && $urandom_range(0, 31) == 0) begin
                req0 = 1'b0;
            end
            if (!req1 && $urandom_range(0, 3) == 0) begin
                req1 = 1'b1; len1 = 1'($urandom_range(0, 1));
                addr1 = 8'($urandom); dat1 = 16'($urandom);
            end else if (req1 && $urandom_range(0, 31) == 0) begin
                req1 = 1'b0;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
